decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage, directly upstream of the execute stage.
//  Accepts 32-bit instruction + PC from fetch over a valid/ready handshake and decodes fields, immediate and a 64-bit one-hot instruction vector.
//  Registers the results in one pipeline register that feeds execute, with backpressure and flush.
//  Counts decoded instructions.
// PARAMETERS
//  N_param   32   datapath width (instruction, PC, imm); only 32 supported
// PORTS
//  i_clk                 in   1   clock; all logic on posedge
//  i_rst                 in   1   synchronous, active-high reset
//  i_flush               in   1   kill the held and incoming instruction (branch/trap redirect)
//  i_valid               in   1   fetch presents an instruction
//  o_ready               out  1   decode can accept this cycle
//  i_instruction         in   32  raw instruction word
//  i_pc                  in   32  PC of i_instruction
//  o_valid               out  1   output register holds a valid decoded instruction
//  i_ready               in   1   execute consumes the output this cycle
//  rd_o / rs1_o / rs2_o  out  5   inst[11:7] / inst[19:15] / inst[24:20], raw, for every format
//  fun3_o                out  3   inst[14:12]
//  fun7_o                out  7   inst[31:25]
//  imm_o                 out  32  decoded immediate (rules below)
//  Single_Instruction_o  out  64  one-hot instruction vector
//  pc_o                  out  32  PC of held instruction
//  o_illegal             out  1   held instruction decoded as inst_UNKNOWN
//  o_decode_count        out  32  instructions accepted and not flushed
// BEHAVIOUR
//  Reset: o_valid=0, all data outputs 0 (Single_Instruction_o=64'd0), o_decode_count=0.
//  o_ready = !o_valid || i_ready (combinational).
//  Accept = i_valid && o_ready; on accept, all outputs load the decode of i_instruction.
//   - Latency is 1 cycle: o_valid rises the cycle after accept.
//  o_valid && i_ready without accept -> o_valid=0; data outputs hold their last value.
//  o_valid && !i_ready -> every output holds stable (no change while stalled).
//  i_flush (priority over accept): o_valid=0 next cycle.
//   - An instruction offered in the same cycle is dropped and not counted.
//   - o_ready still follows its formula.
//  o_decode_count: +1 per accept with i_flush=0; wraps 0xFFFFFFFF->0.
//  One-hot vector: bit index i in list order; inst_X = 64'd1 << i; bits 48..63 always 0.
//   - 0 UNKNOWN, ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU (10)
//   - 11 ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI, SLTI, SLTIU (19)
//   - 20 LB, LH, LW, LBU, LHU, SB, SH, SW (27)
//   - 28 BEQ, BNE, BLT, BGE, BLTU, BGEU (33)
//   - 34 JAL, JALR, LUI, AUIPC, ECALL, EBREAK, FENCE, FENCEI (41)
//   - 42 CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI (47)
//  Decode is strict; any unmatched encoding -> inst_UNKNOWN, o_illegal=1:
//   - inst[1:0] must be 2'b11.
//   - R-type fun7 must be 0000000, or 0100000 for SUB/SRA only.
//   - SLLI/SRLI need fun7=0000000; SRAI needs 0100000.
//   - JALR needs fun3=000.
//   - ECALL == 0x00000073 and EBREAK == 0x00100073 exactly.
//   - FENCE: opcode 0001111 with fun3=000; FENCEI: same opcode with fun3=001.
//   - CSR: opcode 1110011 with fun3 in {1,2,3,5,6,7}.
//  Immediates (sign-extended unless noted):
//   - I-type, loads, JALR: inst[31:20]
//   - S-type: {inst[31:25], inst[11:7]}
//   - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
//   - U-type: {inst[31:12], 12'b0}
//   - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
//   - Shift-immediate: zero-extended inst[24:20]
//   - CSR*: zero-extended inst[31:20] (CSR address); zimm is carried in rs1_o
//   - R-type, FENCE*, ECALL/EBREAK, UNKNOWN: 0
//  Reset mid-stall: the held instruction is discarded, no count is taken, and o_ready=1 next cycle.
// STRUCTURE
//  Shared package riscv_inst_pkg:
//   - index constants, inst_* 64-bit one-hot constants (also used by execute)
//   - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM)
//  Sub-module riscv_decoder_comb: purely combinational instruction -> {fields, imm, one-hot, illegal}.
//  decode_stage adds handshake, pipeline register, flush and counter.
// TESTING
//  ADD x3,x1,x2 (0x002081B3), i_ready=1 -> next cycle: o_valid=1, bit1 set, rd_o=3, rs1_o=1, rs2_o=2, imm_o=0.
//  ADDI x1,x0,-1 (0xFFF00093) -> bit11 set, imm_o=0xFFFFFFFF, o_illegal=0.
//  BEQ x0,x0,-4 (0xFE000EE3) -> bit28 set, imm_o=0xFFFFFFFC.
//  0xFFFFFFFF, also SLLI with fun7=0100000 (0x40009093) -> bit0 set, o_illegal=1, count still increments.
//  Accept, then i_ready=0 for 3 cycles -> o_ready=0 and all outputs stable; i_ready=1 -> next instruction loads.
//  i_flush with i_valid=1 while o_valid=1 -> o_valid=0 next cycle; o_decode_count unchanged.

Source files
------------

// File: rtl/riscv_inst_pkg.sv
// Shared RV32I decode definitions: instruction indices, one-hot instruction
// constants (also consumed by execute), opcodes, immediate formats and the
// decoded-instruction payload.
package riscv_inst_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_BITS = 64;

  // Bit index of each instruction in the one-hot vector.
  localparam logic [5:0] IDX_UNKNOWN = 6'd0;
  localparam logic [5:0] IDX_ADD     = 6'd1;
  localparam logic [5:0] IDX_SUB     = 6'd2;
  localparam logic [5:0] IDX_XOR     = 6'd3;
  localparam logic [5:0] IDX_OR      = 6'd4;
  localparam logic [5:0] IDX_AND     = 6'd5;
  localparam logic [5:0] IDX_SLL     = 6'd6;
  localparam logic [5:0] IDX_SRL     = 6'd7;
  localparam logic [5:0] IDX_SRA     = 6'd8;
  localparam logic [5:0] IDX_SLT     = 6'd9;
  localparam logic [5:0] IDX_SLTU    = 6'd10;
  localparam logic [5:0] IDX_ADDI    = 6'd11;
  localparam logic [5:0] IDX_XORI    = 6'd12;
  localparam logic [5:0] IDX_ORI     = 6'd13;
  localparam logic [5:0] IDX_ANDI    = 6'd14;
  localparam logic [5:0] IDX_SLLI    = 6'd15;
  localparam logic [5:0] IDX_SRLI    = 6'd16;
  localparam logic [5:0] IDX_SRAI    = 6'd17;
  localparam logic [5:0] IDX_SLTI    = 6'd18;
  localparam logic [5:0] IDX_SLTIU   = 6'd19;
  localparam logic [5:0] IDX_LB      = 6'd20;
  localparam logic [5:0] IDX_LH      = 6'd21;
  localparam logic [5:0] IDX_LW      = 6'd22;
  localparam logic [5:0] IDX_LBU     = 6'd23;
  localparam logic [5:0] IDX_LHU     = 6'd24;
  localparam logic [5:0] IDX_SB      = 6'd25;
  localparam logic [5:0] IDX_SH      = 6'd26;
  localparam logic [5:0] IDX_SW      = 6'd27;
  localparam logic [5:0] IDX_BEQ     = 6'd28;
  localparam logic [5:0] IDX_BNE     = 6'd29;
  localparam logic [5:0] IDX_BLT     = 6'd30;
  localparam logic [5:0] IDX_BGE     = 6'd31;
  localparam logic [5:0] IDX_BLTU    = 6'd32;
  localparam logic [5:0] IDX_BGEU    = 6'd33;
  localparam logic [5:0] IDX_JAL     = 6'd34;
  localparam logic [5:0] IDX_JALR    = 6'd35;
  localparam logic [5:0] IDX_LUI     = 6'd36;
  localparam logic [5:0] IDX_AUIPC   = 6'd37;
  localparam logic [5:0] IDX_ECALL   = 6'd38;
  localparam logic [5:0] IDX_EBREAK  = 6'd39;
  localparam logic [5:0] IDX_FENCE   = 6'd40;
  localparam logic [5:0] IDX_FENCEI  = 6'd41;
  localparam logic [5:0] IDX_CSRRW   = 6'd42;
  localparam logic [5:0] IDX_CSRRS   = 6'd43;
  localparam logic [5:0] IDX_CSRRC   = 6'd44;
  localparam logic [5:0] IDX_CSRRWI  = 6'd45;
  localparam logic [5:0] IDX_CSRRSI  = 6'd46;
  localparam logic [5:0] IDX_CSRRCI  = 6'd47;

  // One-hot instruction constants.
  localparam logic [63:0] inst_UNKNOWN = 64'd1 << IDX_UNKNOWN;
  localparam logic [63:0] inst_ADD     = 64'd1 << IDX_ADD;
  localparam logic [63:0] inst_SUB     = 64'd1 << IDX_SUB;
  localparam logic [63:0] inst_XOR     = 64'd1 << IDX_XOR;
  localparam logic [63:0] inst_OR      = 64'd1 << IDX_OR;
  localparam logic [63:0] inst_AND     = 64'd1 << IDX_AND;
  localparam logic [63:0] inst_SLL     = 64'd1 << IDX_SLL;
  localparam logic [63:0] inst_SRL     = 64'd1 << IDX_SRL;
  localparam logic [63:0] inst_SRA     = 64'd1 << IDX_SRA;
  localparam logic [63:0] inst_SLT     = 64'd1 << IDX_SLT;
  localparam logic [63:0] inst_SLTU    = 64'd1 << IDX_SLTU;
  localparam logic [63:0] inst_ADDI    = 64'd1 << IDX_ADDI;
  localparam logic [63:0] inst_XORI    = 64'd1 << IDX_XORI;
  localparam logic [63:0] inst_ORI     = 64'd1 << IDX_ORI;
  localparam logic [63:0] inst_ANDI    = 64'd1 << IDX_ANDI;
  localparam logic [63:0] inst_SLLI    = 64'd1 << IDX_SLLI;
  localparam logic [63:0] inst_SRLI    = 64'd1 << IDX_SRLI;
  localparam logic [63:0] inst_SRAI    = 64'd1 << IDX_SRAI;
  localparam logic [63:0] inst_SLTI    = 64'd1 << IDX_SLTI;
  localparam logic [63:0] inst_SLTIU   = 64'd1 << IDX_SLTIU;
  localparam logic [63:0] inst_LB      = 64'd1 << IDX_LB;
  localparam logic [63:0] inst_LH      = 64'd1 << IDX_LH;
  localparam logic [63:0] inst_LW      = 64'd1 << IDX_LW;
  localparam logic [63:0] inst_LBU     = 64'd1 << IDX_LBU;
  localparam logic [63:0] inst_LHU     = 64'd1 << IDX_LHU;
  localparam logic [63:0] inst_SB      = 64'd1 << IDX_SB;
  localparam logic [63:0] inst_SH      = 64'd1 << IDX_SH;
  localparam logic [63:0] inst_SW      = 64'd1 << IDX_SW;
  localparam logic [63:0] inst_BEQ     = 64'd1 << IDX_BEQ;
  localparam logic [63:0] inst_BNE     = 64'd1 << IDX_BNE;
  localparam logic [63:0] inst_BLT     = 64'd1 << IDX_BLT;
  localparam logic [63:0] inst_BGE     = 64'd1 << IDX_BGE;
  localparam logic [63:0] inst_BLTU    = 64'd1 << IDX_BLTU;
  localparam logic [63:0] inst_BGEU    = 64'd1 << IDX_BGEU;
  localparam logic [63:0] inst_JAL     = 64'd1 << IDX_JAL;
  localparam logic [63:0] inst_JALR    = 64'd1 << IDX_JALR;
  localparam logic [63:0] inst_LUI     = 64'd1 << IDX_LUI;
  localparam logic [63:0] inst_AUIPC   = 64'd1 << IDX_AUIPC;
  localparam logic [63:0] inst_ECALL   = 64'd1 << IDX_ECALL;
  localparam logic [63:0] inst_EBREAK  = 64'd1 << IDX_EBREAK;
  localparam logic [63:0] inst_FENCE   = 64'd1 << IDX_FENCE;
  localparam logic [63:0] inst_FENCEI  = 64'd1 << IDX_FENCEI;
  localparam logic [63:0] inst_CSRRW   = 64'd1 << IDX_CSRRW;
  localparam logic [63:0] inst_CSRRS   = 64'd1 << IDX_CSRRS;
  localparam logic [63:0] inst_CSRRC   = 64'd1 << IDX_CSRRC;
  localparam logic [63:0] inst_CSRRWI  = 64'd1 << IDX_CSRRWI;
  localparam logic [63:0] inst_CSRRSI  = 64'd1 << IDX_CSRRSI;
  localparam logic [63:0] inst_CSRRCI  = 64'd1 << IDX_CSRRCI;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [6:0] FUN7_BASE = 7'b0000000;
  localparam logic [6:0] FUN7_ALT  = 7'b0100000;

  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  // Immediate layout selected by the decoder.
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SH,
    FMT_CSR
  } imm_fmt_e;

  // Decoded-instruction payload handed from decoder to pipeline register.
  typedef struct packed {
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           fun3;
    logic [6:0]           fun7;
    logic [XLEN-1:0]      imm;
    logic [INST_BITS-1:0] onehot;
    logic                 illegal;
  } dec_t;

endpackage

// File: rtl/riscv_decoder_comb.sv
// Purely combinational RV32I decoder.
// Ports:
//   inst   in   32   raw instruction word
//   dec_c  out  dec_t  raw register fields, immediate, one-hot vector, illegal
module riscv_decoder_comb
  import riscv_inst_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output dec_t            dec_c
);

  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic [5:0] idx;
  imm_fmt_e   fmt;

  assign opcode = inst[6:0];
  assign fun3   = inst[14:12];
  assign fun7   = inst[31:25];

  // Instruction match; anything not matched keeps the UNKNOWN index and no immediate.
  always_comb begin
    idx = IDX_UNKNOWN;
    fmt = FMT_NONE;
    case (opcode)
      OP: begin
        if (fun7 == FUN7_BASE) begin
          case (fun3)
            3'd0: idx = IDX_ADD;
            3'd1: idx = IDX_SLL;
            3'd2: idx = IDX_SLT;
            3'd3: idx = IDX_SLTU;
            3'd4: idx = IDX_XOR;
            3'd5: idx = IDX_SRL;
            3'd6: idx = IDX_OR;
            3'd7: idx = IDX_AND;
            default: ;
          endcase
        end else if (fun7 == FUN7_ALT) begin
          case (fun3)
            3'd0: idx = IDX_SUB;
            3'd5: idx = IDX_SRA;
            default: ;
          endcase
        end
      end
      OP_IMM: begin
        case (fun3)
          3'd0: begin idx = IDX_ADDI;  fmt = FMT_I; end
          3'd2: begin idx = IDX_SLTI;  fmt = FMT_I; end
          3'd3: begin idx = IDX_SLTIU; fmt = FMT_I; end
          3'd4: begin idx = IDX_XORI;  fmt = FMT_I; end
          3'd6: begin idx = IDX_ORI;   fmt = FMT_I; end
          3'd7: begin idx = IDX_ANDI;  fmt = FMT_I; end
          3'd1: begin
            if (fun7 == FUN7_BASE) begin idx = IDX_SLLI; fmt = FMT_SH; end
          end
          3'd5: begin
            if (fun7 == FUN7_BASE) begin
              idx = IDX_SRLI; fmt = FMT_SH;
            end else if (fun7 == FUN7_ALT) begin
              idx = IDX_SRAI; fmt = FMT_SH;
            end
          end
          default: ;
        endcase
      end
      LOAD: begin
        case (fun3)
          3'd0: begin idx = IDX_LB;  fmt = FMT_I; end
          3'd1: begin idx = IDX_LH;  fmt = FMT_I; end
          3'd2: begin idx = IDX_LW;  fmt = FMT_I; end
          3'd4: begin idx = IDX_LBU; fmt = FMT_I; end
          3'd5: begin idx = IDX_LHU; fmt = FMT_I; end
          default: ;
        endcase
      end
      STORE: begin
        case (fun3)
          3'd0: begin idx = IDX_SB; fmt = FMT_S; end
          3'd1: begin idx = IDX_SH; fmt = FMT_S; end
          3'd2: begin idx = IDX_SW; fmt = FMT_S; end
          default: ;
        endcase
      end
      BRANCH: begin
        case (fun3)
          3'd0: begin idx = IDX_BEQ;  fmt = FMT_B; end
          3'd1: begin idx = IDX_BNE;  fmt = FMT_B; end
          3'd4: begin idx = IDX_BLT;  fmt = FMT_B; end
          3'd5: begin idx = IDX_BGE;  fmt = FMT_B; end
          3'd6: begin idx = IDX_BLTU; fmt = FMT_B; end
          3'd7: begin idx = IDX_BGEU; fmt = FMT_B; end
          default: ;
        endcase
      end
      JAL:   begin idx = IDX_JAL;   fmt = FMT_J; end
      JALR: begin
        if (fun3 == 3'd0) begin idx = IDX_JALR; fmt = FMT_I; end
      end
      LUI:   begin idx = IDX_LUI;   fmt = FMT_U; end
      AUIPC: begin idx = IDX_AUIPC; fmt = FMT_U; end
      MISC_MEM: begin
        case (fun3)
          3'd0: idx = IDX_FENCE;
          3'd1: idx = IDX_FENCEI;
          default: ;
        endcase
      end
      SYSTEM: begin
        // ECALL/EBREAK must match the whole word; fun3=0/4 are otherwise illegal.
        if (inst == ECALL_WORD) begin
          idx = IDX_ECALL;
        end else if (inst == EBREAK_WORD) begin
          idx = IDX_EBREAK;
        end else begin
          case (fun3)
            3'd1: begin idx = IDX_CSRRW;  fmt = FMT_CSR; end
            3'd2: begin idx = IDX_CSRRS;  fmt = FMT_CSR; end
            3'd3: begin idx = IDX_CSRRC;  fmt = FMT_CSR; end
            3'd5: begin idx = IDX_CSRRWI; fmt = FMT_CSR; end
            3'd6: begin idx = IDX_CSRRSI; fmt = FMT_CSR; end
            3'd7: begin idx = IDX_CSRRCI; fmt = FMT_CSR; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Immediate assembly and payload.
  always_comb begin
    dec_c      = '0;
    dec_c.rd   = inst[11:7];
    dec_c.rs1  = inst[19:15];
    dec_c.rs2  = inst[24:20];
    dec_c.fun3 = fun3;
    dec_c.fun7 = fun7;
    case (fmt)
      FMT_I:   dec_c.imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   dec_c.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   dec_c.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   dec_c.imm = {inst[31:12], 12'b0};
      FMT_J:   dec_c.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_SH:  dec_c.imm = {27'b0, inst[24:20]};
      FMT_CSR: dec_c.imm = {20'b0, inst[31:20]};
      default: dec_c.imm = '0;
    endcase
    dec_c.onehot  = 64'd1 << idx;
    dec_c.illegal = (dec_c.onehot == inst_UNKNOWN);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready input from fetch, one registered output
// slot toward execute with backpressure and flush, and an accept counter.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_flush                           kill held and incoming instruction
//   i_valid / o_ready                 fetch handshake (o_ready combinational)
//   i_instruction, i_pc               instruction word and its PC
//   o_valid / i_ready                 execute handshake
//   rd_o, rs1_o, rs2_o, fun3_o, fun7_o  raw instruction fields
//   imm_o, Single_Instruction_o       immediate and one-hot instruction
//   pc_o, o_illegal, o_decode_count   held PC, UNKNOWN flag, accept count
module decode_stage
  import riscv_inst_pkg::*;
#(
  parameter int unsigned N_param = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N_param-1:0] i_instruction,
  input  logic [N_param-1:0] i_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [2:0]         fun3_o,
  output logic [6:0]         fun7_o,
  output logic [N_param-1:0] imm_o,
  output logic [63:0]        Single_Instruction_o,
  output logic [N_param-1:0] pc_o,
  output logic               o_illegal,
  output logic [31:0]        o_decode_count
);

  dec_t               dec_c;
  dec_t               dec_q, dec_d;
  logic               valid_q, valid_d;
  logic [N_param-1:0] pc_q, pc_d;
  logic [31:0]        count_q, count_d;
  logic               accept;

  riscv_decoder_comb u_decoder (
    .inst  (i_instruction),
    .dec_c (dec_c)
  );

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Output-slot update: flush wins over accept; data holds whenever not loading.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_c;
      pc_d    = i_pc;
      count_d = count_q + 32'd1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign o_valid              = valid_q;
  assign rd_o                 = dec_q.rd;
  assign rs1_o                = dec_q.rs1;
  assign rs2_o                = dec_q.rs2;
  assign fun3_o               = dec_q.fun3;
  assign fun7_o               = dec_q.fun7;
  assign imm_o                = dec_q.imm;
  assign Single_Instruction_o = dec_q.onehot;
  assign pc_o                 = pc_q;
  assign o_illegal            = dec_q.illegal;
  assign o_decode_count       = count_q;

endmodule
